// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM for a MIPS-style CPU: sequences fetch, execute, memory
// and multiply/divide stalls, and decodes the datapath control strobes.
module cpu_control_fsm #(
  parameter int unsigned MULTDIV_CYCLES = 34,
  parameter int unsigned LANES          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       function_i,
  input  logic [1:0]       addr_lo_i,
  input  logic             branch_taken_i,
  input  logic             pc_next_zero_i,
  output logic [2:0]       state_o,
  output logic             active_o,
  output logic             pc_write_en_o,
  output logic             ir_write_en_o,
  output logic             ram_read_en_o,
  output logic             ram_write_en_o,
  output logic             ram_addr_sel_o,
  output logic             src_b_sel_o,
  output logic             regfile_write_en_o,
  output logic             hilo_write_en_o,
  output logic             multdiv_start_o,
  output logic [LANES-1:0] ram_byte_en_o,
  output logic [1:0]       pc_sel_o,
  output logic [1:0]       regfile_addr_3_sel_o
);

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StExec1 = 3'd1,
    StExec2 = 3'd2,
    StStall = 3'd3,
    StHalt  = 3'd4
  } state_e;

  localparam logic [5:0] OpSpecial = 6'h00, OpJ    = 6'h02, OpJal  = 6'h03, OpBeq  = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05, OpBlez = 6'h06, OpBgtz = 6'h07, OpAddi = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09, OpSlti = 6'h0a, OpSltiu = 6'h0b, OpAndi = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d, OpXori = 6'h0e, OpLui  = 6'h0f, OpLb   = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21, OpLw   = 6'h23, OpLbu  = 6'h24, OpLhu  = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28, OpSh   = 6'h29, OpSw   = 6'h2b;

  localparam logic [5:0] FnSll  = 6'h00, FnSrl  = 6'h02, FnSra  = 6'h03, FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06, FnSrav = 6'h07, FnJr   = 6'h08, FnJalr = 6'h09;
  localparam logic [5:0] FnMfhi = 6'h10, FnMthi = 6'h11, FnMflo = 6'h12, FnMtlo = 6'h13;
  localparam logic [5:0] FnMult = 6'h18, FnMultu = 6'h19, FnDiv = 6'h1a, FnDivu = 6'h1b;
  localparam logic [5:0] FnAdd  = 6'h20, FnAddu = 6'h21, FnSub  = 6'h22, FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24, FnOr   = 6'h25, FnXor  = 6'h26, FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a, FnSltu = 6'h2b;

  localparam logic [7:0] CountInit = 8'(MULTDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic       ir_loaded_q, ir_loaded_d;
  logic [7:0] count_q, count_d;

  logic is_load, is_store, is_alu_imm, is_alu_r, is_mfhl, is_mthl, is_multdiv;
  logic is_j, is_jal, is_jr, is_jalr, is_branch, size_word, size_half;
  logic exit_cycle;
  logic [LANES-1:0] mem_be;

  // Instruction class decode from the IR fields.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_alu_imm = 1'b0;
    is_alu_r   = 1'b0;
    is_mfhl    = 1'b0;
    is_mthl    = 1'b0;
    is_multdiv = 1'b0;
    is_j       = 1'b0;
    is_jal     = 1'b0;
    is_jr      = 1'b0;
    is_jalr    = 1'b0;
    is_branch  = 1'b0;
    size_word  = 1'b0;
    size_half  = 1'b0;
    case (opcode_i)
      OpSpecial: begin
        case (function_i)
          FnJr:                                 is_jr      = 1'b1;
          FnJalr:                               is_jalr    = 1'b1;
          FnMfhi, FnMflo:                       is_mfhl    = 1'b1;
          FnMthi, FnMtlo:                       is_mthl    = 1'b1;
          FnMult, FnMultu, FnDiv, FnDivu:       is_multdiv = 1'b1;
          FnSll, FnSrl, FnSra, FnSllv, FnSrlv, FnSrav,
          FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr,
          FnXor, FnNor, FnSlt, FnSltu:          is_alu_r   = 1'b1;
          default: ;
        endcase
      end
      OpJ:                                      is_j       = 1'b1;
      OpJal:                                    is_jal     = 1'b1;
      OpBeq, OpBne, OpBlez, OpBgtz:             is_branch  = 1'b1;
      OpAddi, OpAddiu, OpSlti, OpSltiu,
      OpAndi, OpOri, OpXori, OpLui:             is_alu_imm = 1'b1;
      OpLb, OpLbu:                              is_load    = 1'b1;
      OpLh, OpLhu: begin
        is_load   = 1'b1;
        size_half = 1'b1;
      end
      OpLw: begin
        is_load   = 1'b1;
        size_word = 1'b1;
      end
      OpSb:                                     is_store   = 1'b1;
      OpSh: begin
        is_store  = 1'b1;
        size_half = 1'b1;
      end
      OpSw: begin
        is_store  = 1'b1;
        size_word = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (size_word) begin
      mem_be = LANES'(4'b1111);
    end else if (size_half) begin
      mem_be = addr_lo_i[1] ? LANES'(4'b1100) : LANES'(4'b0011);
    end else begin
      mem_be = LANES'(4'b0001 << addr_lo_i);
    end
  end

  always_comb begin
    state_d              = state_q;
    count_d              = count_q;
    ir_loaded_d          = ir_loaded_q;
    exit_cycle           = 1'b0;
    state_o              = 3'(state_q);
    active_o             = (state_q != StHalt);
    pc_write_en_o        = 1'b0;
    ir_write_en_o        = 1'b0;
    ram_read_en_o        = 1'b0;
    ram_write_en_o       = 1'b0;
    ram_addr_sel_o       = 1'b0;
    src_b_sel_o          = 1'b0;
    regfile_write_en_o   = 1'b0;
    hilo_write_en_o      = 1'b0;
    multdiv_start_o      = 1'b0;
    ram_byte_en_o        = '0;
    pc_sel_o             = 2'd0;
    regfile_addr_3_sel_o = 2'd0;

    case (state_q)
      StFetch: begin
        ram_read_en_o = 1'b1;
        ram_byte_en_o = LANES'(4'b1111);
        if (!waitrequest_i) state_d = StExec1;
      end
      StExec1: begin
        ir_write_en_o = !ir_loaded_q;
        ir_loaded_d   = 1'b1;
        if (is_load) begin
          ram_read_en_o  = 1'b1;
          ram_addr_sel_o = 1'b1;
          src_b_sel_o    = 1'b1;
          ram_byte_en_o  = mem_be;
        end
        if (!is_load || !waitrequest_i) begin
          state_d     = StExec2;
          ir_loaded_d = 1'b0;
        end
      end
      StExec2: begin
        if (is_store) begin
          ram_write_en_o = 1'b1;
          ram_addr_sel_o = 1'b1;
          src_b_sel_o    = 1'b1;
          ram_byte_en_o  = mem_be;
          exit_cycle     = !waitrequest_i;
        end else if (is_multdiv) begin
          multdiv_start_o = 1'b1;
          count_d         = CountInit;
          state_d         = StStall;
        end else begin
          exit_cycle = 1'b1;
        end
        if (exit_cycle) begin
          pc_write_en_o      = 1'b1;
          hilo_write_en_o    = is_mthl;
          regfile_write_en_o = is_load | is_alu_imm | is_alu_r | is_mfhl | is_jal | is_jalr;
          if (is_jal) begin
            regfile_addr_3_sel_o = 2'd2;
          end else if (is_alu_r || is_mfhl || is_jalr) begin
            regfile_addr_3_sel_o = 2'd1;
          end
          if (is_branch && branch_taken_i) begin
            pc_sel_o = 2'd1;
          end else if (is_j || is_jal) begin
            pc_sel_o = 2'd2;
          end else if (is_jr || is_jalr) begin
            pc_sel_o = 2'd3;
          end
        end
      end
      StStall: begin
        if (count_q == 8'd0) begin
          hilo_write_en_o = 1'b1;
          pc_write_en_o   = 1'b1;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase

    // Jumping to address zero means the program has returned: stop.
    if (pc_write_en_o) state_d = pc_next_zero_i ? StHalt : StFetch;

    if (reset) begin
      state_o              = 3'd0;
      active_o             = 1'b1;
      pc_write_en_o        = 1'b0;
      ir_write_en_o        = 1'b0;
      ram_read_en_o        = 1'b0;
      ram_write_en_o       = 1'b0;
      ram_addr_sel_o       = 1'b0;
      src_b_sel_o          = 1'b0;
      regfile_write_en_o   = 1'b0;
      hilo_write_en_o      = 1'b0;
      multdiv_start_o      = 1'b0;
      ram_byte_en_o        = '0;
      pc_sel_o             = 2'd0;
      regfile_addr_3_sel_o = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      count_q     <= 8'd0;
      ir_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ir_loaded_q <= ir_loaded_d;
    end
  end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 SHALL have parameter MULTDIV_CYCLES, default 34: EXEC2 stall length for MULT/MULTU/DIV/DIVU; legal range 2..255.
REQ-002 SHALL have parameter LANES, default 4: width of ram_byte_en_o; only value 4 is legal.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port waitrequest_i, input, 1 bit: memory busy; the current access is held while it is high.
REQ-006 SHALL have ports opcode_i (6 bits) and function_i (6 bits), inputs: fields of the instruction register.
REQ-007 SHALL have port addr_lo_i, input, 2 bits: effective-address bits [1:0] for loads and stores.
REQ-008 SHALL have port branch_taken_i, input, 1 bit: branch condition from the ALU for BEQ/BNE/BLEZ/BGTZ.
REQ-009 SHALL have port pc_next_zero_i, input, 1 bit: the next-PC value is 0x00000000.
REQ-010 SHALL have port state_o, output, 3 bits: encoding FETCH=0, EXEC1=1, EXEC2=2, STALL=3, HALT=4.
REQ-011 SHALL have port active_o, output, 1 bit: CPU running.
REQ-012 SHALL have outputs pc_write_en_o, ir_write_en_o, ram_read_en_o, ram_write_en_o, ram_addr_sel_o, src_b_sel_o, regfile_write_en_o, hilo_write_en_o and multdiv_start_o, each 1 bit.
REQ-013 SHALL have outputs ram_byte_en_o (LANES bits), pc_sel_o (2 bits: 0 seq, 1 branch, 2 jump-imm, 3 jump-reg) and regfile_addr_3_sel_o (2 bits: 0 RT, 1 RD, 2 R31).

Function
REQ-014 All outputs SHALL be decoded from the registered state, the ir_loaded flag, the stall counter and the inputs; they SHALL be 0 in HALT.
REQ-015 FETCH SHALL drive ram_read_en_o=1 and ram_byte_en_o=1111; it SHALL stay in FETCH while waitrequest_i=1, otherwise go to EXEC1.
REQ-016 ir_write_en_o SHALL be 1 only in the first EXEC1 cycle; the ir_loaded flag SHALL set on that cycle and clear when leaving EXEC1.
REQ-017 For loads, EXEC1 SHALL drive ram_read_en_o=1, ram_addr_sel_o=1 and src_b_sel_o=1.
REQ-018 For loads, EXEC1 SHALL stay while waitrequest_i=1 and otherwise go to EXEC2; for all other instructions EXEC1 SHALL go to EXEC2 after one cycle.
REQ-019 Byte enables for LW/SW SHALL be 1111.
REQ-020 Byte enables for LH/LHU/SH SHALL be 0011 when addr_lo_i[1]=0 and 1100 when addr_lo_i[1]=1.
REQ-021 Byte enables for LB/LBU/SB SHALL be 0001 shifted left by addr_lo_i.
REQ-022 For stores, EXEC2 SHALL drive ram_write_en_o=1, ram_addr_sel_o=1 and src_b_sel_o=1, and SHALL hold in EXEC2 while waitrequest_i=1.
REQ-023 pc_write_en_o SHALL be 1 only in the EXEC2 cycle that exits to FETCH, or in the final STALL cycle.
REQ-024 regfile_write_en_o SHALL be 1 in the exit cycle for loads, immediate ALU ops and R-type ALU/shift/MFHI/MFLO; R-type SHALL select RD.
REQ-025 JAL SHALL write with regfile_addr_3_sel_o=R31; JALR SHALL write with RD.
REQ-026 pc_sel_o in the exit cycle SHALL be: 1 for a branch with branch_taken_i=1; 2 for J/JAL; 3 for JR/JALR; 0 otherwise.
REQ-027 MULT/MULTU/DIV/DIVU SHALL pulse multdiv_start_o for one cycle in EXEC2, load the counter with MULTDIV_CYCLES-1 and go to STALL.
REQ-028 STALL SHALL decrement the counter each cycle; at count 0 it SHALL assert hilo_write_en_o and pc_write_en_o and go to FETCH.
REQ-029 MTHI/MTLO SHALL assert hilo_write_en_o in the exit cycle of EXEC2.
REQ-030 If pc_write_en_o=1 and pc_next_zero_i=1, the next state SHALL be HALT, not FETCH; HALT SHALL be left only by reset.
REQ-031 Undefined opcode/function values SHALL behave as a NOP: EXEC2 advances the PC only.
REQ-032 waitrequest_i SHALL be ignored in states that issue no memory access.

Reset
REQ-033 While reset=1 the next state SHALL be FETCH and the counter and ir_loaded SHALL clear.
REQ-034 While reset=1 all outputs SHALL be 0 except active_o=1.
REQ-035 A reset asserted during STALL or a held access SHALL abort it with no hilo, pc or regfile write.

Verification
REQ-036 ADDU, no wait states -> FETCH,EXEC1,EXEC2; regfile_write_en_o=1 and regfile_addr_3_sel_o=1 in EXEC2; pc_write_en_o=1 once.
REQ-037 LB with addr_lo_i=2 and waitrequest_i high for 3 EXEC1 cycles -> ram_byte_en_o=0100; EXEC1 lasts 4 cycles; ir_write_en_o only in the first.
REQ-038 DIV with MULTDIV_CYCLES=34 -> one multdiv_start_o pulse; 34 STALL cycles; hilo_write_en_o and pc_write_en_o only in the last.
REQ-039 JR with pc_next_zero_i=1 -> pc_sel_o=3 and pc_write_en_o=1, then state HALT with active_o=0; it stays in HALT for 100 cycles.
REQ-040 BEQ with branch_taken_i=1 -> pc_sel_o=1; BNE with branch_taken_i=0 -> pc_sel_o=0; regfile_write_en_o=0 in both.
REQ-041 Reset at STALL count 10 -> FETCH next cycle; no hilo_write_en_o at any point.
